seg_display_scheduler: RTL

Shares the 4-digit seven-segment display between four requesters (counter, timer, status, debug). Grants display ownership round-robin with a minimum dwell time per owner. Converts the owner's 14-bit binary value to four BCD digits with a sequential double-dabble engine, and publishes stable digits plus leading-zero blanking to the digit-multiplex driver. This replaces per-digit divide/modulo arithmetic in the driver; the driver only scans what this block presents.

---
 rtl/display_pkg.sv | 39 +++
 rtl/bin2bcd_seq.sv | 72 +++++++
 rtl/seg_display_scheduler.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// display_pkg
// Shared types, constants and helper functions for the seven-segment
// display scheduler: controller state encoding, display geometry,
// the leading-zero blanking rule and the double-dabble nibble correction.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SHOW    = 2'd2
  } state_t;

  localparam int NUM_DIGITS  = 4;
  localparam int MAX_DISPLAY = 9999;
  localparam int BCD_W       = 16;

  // Leading-zero blanking: a digit is blanked only if it and every digit to
  // its left are zero. The units digit is never blanked, so 0 shows as "0".
  function automatic logic [NUM_DIGITS-1:0] blank_f(input logic [BCD_W-1:0] bcd);
    logic [NUM_DIGITS-1:0] b;
    b[3] = (bcd[15:12] == 4'd0);
    b[2] = b[3] & (bcd[11:8] == 4'd0);
    b[1] = b[2] & (bcd[7:4] == 4'd0);
    b[0] = 1'b0;
    return b;
  endfunction

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
  // so that the shift carries correctly into the next decade.
  function automatic logic [BCD_W-1:0] dabble_adjust_f(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? (bcd[4*i +: 4] + 4'd3) : bcd[4*i +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential double-dabble binary-to-BCD converter, one iteration per clock.
// A start pulse loads the binary operand; VAL_W iterations follow. done is
// high during the cycle whose closing edge performs the last iteration, and
// bcd carries that iteration's result, so the caller can register the final
// digits on the same edge that done marks.
// Ports:
//   clock_100Mhz  system clock
//   reset         synchronous, active-high
//   start         load bin and begin a conversion (ignored bits: none)
//   bin           binary operand, VAL_W bits
//   done          last-iteration marker (combinational, one cycle)
//   bcd           result of the iteration performed at the next edge
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int VAL_W = 14
) (
  input  logic             clock_100Mhz,
  input  logic             reset,
  input  logic             start,
  input  logic [VAL_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int CNT_W = $clog2(VAL_W);

  logic [VAL_W-1:0] bin_r;
  logic [BCD_W-1:0] bcd_r;
  logic [CNT_W-1:0] cnt_r;
  logic             active_r;
  logic [BCD_W-1:0] adj_s;
  logic [BCD_W-1:0] step_bcd_s;
  logic             last_s;

  // One iteration: correct the nibbles, then shift the binary MSB in.
  always_comb begin
    adj_s      = dabble_adjust_f(bcd_r);
    step_bcd_s = {adj_s[BCD_W-2:0], bin_r[VAL_W-1]};
  end

  assign last_s = active_r && (cnt_r == CNT_W'(VAL_W - 1));
  assign done   = last_s;
  assign bcd    = step_bcd_s;

  // Iteration state: load on start, advance one bit per cycle, stop after the last bit.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      active_r <= 1'b0;
      cnt_r    <= '0;
      bin_r    <= '0;
      bcd_r    <= '0;
    end else if (start) begin
      active_r <= 1'b1;
      cnt_r    <= '0;
      bin_r    <= bin;
      bcd_r    <= '0;
    end else if (active_r) begin
      active_r <= ~last_s;
      cnt_r    <= cnt_r + CNT_W'(1);
      bin_r    <= {bin_r[VAL_W-2:0], 1'b0};
      bcd_r    <= step_bcd_s;
    end else begin
      active_r <= active_r;
      cnt_r    <= cnt_r;
      bin_r    <= bin_r;
      bcd_r    <= bcd_r;
    end
  end

endmodule

// File: rtl/seg_display_scheduler.sv
// seg_display_scheduler
// Shares the 4-digit seven-segment display between four requesters. Grants
// ownership round-robin with a minimum dwell time, saturates the owner's
// value at 9999, converts it to BCD with a sequential double-dabble engine
// and publishes stable digits plus leading-zero blanking to the scan driver.
// Ports:
//   clock_100Mhz  system clock
//   reset         synchronous, active-high
//   req           per-requester request, level-sensitive
//   value         packed values, requester i at [i*VAL_W +: VAL_W]
//   grant         one-hot current owner, 0 when idle
//   src_id        index of the current owner
//   bcd_digits    [15:12] thousands .. [3:0] units
//   digit_blank   per-digit blank, same ordering as bcd_digits
//   bcd_valid     bcd_digits hold a completed conversion
//   overflow      displayed value was saturated
//   busy          conversion in progress
module seg_display_scheduler
  import display_pkg::*;
#(
  parameter int NUM_SRC      = 4,
  parameter int VAL_W        = 14,
  parameter int DWELL_CYCLES = 100_000_000
) (
  input  logic                     clock_100Mhz,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       req,
  input  logic [NUM_SRC*VAL_W-1:0] value,
  output logic [NUM_SRC-1:0]       grant,
  output logic [1:0]               src_id,
  output logic [BCD_W-1:0]         bcd_digits,
  output logic [NUM_DIGITS-1:0]    digit_blank,
  output logic                     bcd_valid,
  output logic                     overflow,
  output logic                     busy
);

  localparam int DW_W = $clog2(DWELL_CYCLES + 1);

  state_t                  state_r;
  state_t                  state_nx_s;
  logic [NUM_SRC-1:0]      grant_r;
  logic [1:0]              src_id_r;
  logic [1:0]              last_id_r;
  logic                    ovf_pend_r;
  logic [BCD_W-1:0]        digits_r;
  logic [NUM_DIGITS-1:0]   blank_r;
  logic                    valid_r;
  logic                    ovf_r;
  logic                    busy_r;
  logic [DW_W-1:0]         dwell_r;

  logic                    any_req_s;
  logic [1:0]              cand_s;
  logic [1:0]              sel_id_s;
  logic [VAL_W-1:0]        sel_val_s;
  logic                    sat_ovf_s;
  logic [VAL_W-1:0]        sat_val_s;
  logic                    start_s;
  logic                    go_idle_s;
  logic                    dwell_end_s;
  logic                    publish_s;
  logic                    conv_done_s;
  logic [BCD_W-1:0]        conv_bcd_s;

  assign any_req_s = |req;

  // Round-robin search from last_id+1; scanning from the far end lets the
  // nearest set request overwrite, so the first one after last_id wins and
  // the previous owner is reached last (it wins only if it is alone).
  always_comb begin
    cand_s   = 2'd0;
    sel_id_s = last_id_r;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand_s   = last_id_r + 2'(k);
      sel_id_s = req[cand_s] ? cand_s : sel_id_s;
    end
  end

  // Saturation of the selected value to the largest displayable number.
  always_comb begin
    sel_val_s = value[sel_id_s*VAL_W +: VAL_W];
    sat_ovf_s = (sel_val_s > VAL_W'(MAX_DISPLAY));
    sat_val_s = sat_ovf_s ? VAL_W'(MAX_DISPLAY) : sel_val_s;
  end

  assign publish_s = (state_r == CONVERT) && conv_done_s;

  // Next-state logic: select from IDLE or at SHOW exit, otherwise hold or advance.
  always_comb begin
    state_nx_s  = state_r;
    start_s     = 1'b0;
    go_idle_s   = 1'b0;
    dwell_end_s = (dwell_r == DW_W'(DWELL_CYCLES - 1)) || !req[src_id_r];
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          start_s    = 1'b1;
          state_nx_s = CONVERT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CONVERT: begin
        if (conv_done_s) begin
          state_nx_s = SHOW;
        end else begin
          state_nx_s = CONVERT;
        end
      end
      SHOW: begin
        if (dwell_end_s) begin
          if (any_req_s) begin
            start_s    = 1'b1;
            state_nx_s = CONVERT;
          end else begin
            go_idle_s  = 1'b1;
            state_nx_s = IDLE;
          end
        end else begin
          state_nx_s = SHOW;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register and busy flag, which mirrors the CONVERT state.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s == CONVERT);
    end
  end

  // Ownership: grant, owner index, rotation pointer and pending saturation flag.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      grant_r    <= '0;
      src_id_r   <= 2'd0;
      last_id_r  <= 2'd3;
      ovf_pend_r <= 1'b0;
    end else if (start_s) begin
      grant_r    <= {{(NUM_SRC-1){1'b0}}, 1'b1} << sel_id_s;
      src_id_r   <= sel_id_s;
      last_id_r  <= sel_id_s;
      ovf_pend_r <= sat_ovf_s;
    end else if (go_idle_s) begin
      grant_r    <= '0;
      src_id_r   <= src_id_r;
      last_id_r  <= last_id_r;
      ovf_pend_r <= ovf_pend_r;
    end else begin
      grant_r    <= grant_r;
      src_id_r   <= src_id_r;
      last_id_r  <= last_id_r;
      ovf_pend_r <= ovf_pend_r;
    end
  end

  // Published display: changes only on a completed conversion or when going idle.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      digits_r <= '0;
      blank_r  <= 4'b1111;
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
    end else if (publish_s) begin
      digits_r <= conv_bcd_s;
      blank_r  <= blank_f(conv_bcd_s);
      valid_r  <= 1'b1;
      ovf_r    <= ovf_pend_r;
    end else if (go_idle_s) begin
      digits_r <= digits_r;
      blank_r  <= 4'b1111;
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      digits_r <= digits_r;
      blank_r  <= blank_r;
      valid_r  <= valid_r;
      ovf_r    <= ovf_r;
    end
  end

  // Dwell counter: cleared at publish, counts every SHOW cycle.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      dwell_r <= '0;
    end else if (publish_s) begin
      dwell_r <= '0;
    end else if (state_r == SHOW) begin
      dwell_r <= dwell_r + DW_W'(1);
    end else begin
      dwell_r <= dwell_r;
    end
  end

  bin2bcd_seq #(
    .VAL_W (VAL_W)
  ) u_bin2bcd (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .start        (start_s),
    .bin          (sat_val_s),
    .done         (conv_done_s),
    .bcd          (conv_bcd_s)
  );

  assign grant       = grant_r;
  assign src_id      = src_id_r;
  assign bcd_digits  = digits_r;
  assign digit_blank = blank_r;
  assign bcd_valid   = valid_r;
  assign overflow    = ovf_r;
  assign busy        = busy_r;

endmodule
